// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO read-side drain controller.
// Holds the FSM state encoding and the minimum skid depth.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } drain_state_t;

  localparam int MIN_SKID = 2;

endpackage

// File: rtl/fifo_drain_skid.sv
// Small synchronous output FIFO between the FIFO read port and the stream.
// Head is read straight from storage registers; push and pop may coincide.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = MIN_SKID,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [OCC_W-1:0]  occ_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (occ_q != '0);
  // A push into a full buffer is legal only when the head leaves this cycle.
  assign do_push = push_i &&
                   ((occ_q != OCC_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: issues FIFO reads for a commanded length
// and presents the words as a valid/ready stream with last and done.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 4,
  parameter int SKID_DEPTH = 2
) (
  input  logic              read_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_left
);

  localparam int DEPTH =
    (SKID_DEPTH < MIN_SKID) ? MIN_SKID : SKID_DEPTH;
  localparam int OCC_W = $clog2(DEPTH + 1);

  drain_state_t     state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] words_left_q;
  logic             inflight_q;

  logic [OCC_W-1:0] occ;
  logic             pop;

  fifo_drain_skid #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .OCC_W  (OCC_W)
  ) u_skid (
    .clk_i   (read_clk),
    .reset_i (reset),
    .push_i  (inflight_q),
    .data_i  (fifo_data),
    .pop_i   (pop),
    .occ_o   (occ),
    .head_o  (out_data)
  );

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (words_left_q == LEN_W'(1));
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign words_left = words_left_q;

  // Reserve a skid slot for every read still in flight.
  always_comb begin
    fifo_rd_en = 1'b0;
    if ((state_q == RUN) && !fifo_empty &&
        (issued_q < len_q) &&
        ((int'(occ) + int'(inflight_q) - int'(pop)) < DEPTH)) begin
      fifo_rd_en = 1'b1;
    end
  end

  always_ff @(posedge read_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (pop) begin
        words_left_q <= words_left_q - LEN_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q        <= xfer_len;
            issued_q     <= '0;
            words_left_q <= xfer_len;
            state_q      <= (xfer_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fifo_rd_en) begin
            issued_q <= issued_q + LEN_W'(1);
          end
          if ((issued_q + LEN_W'(fifo_rd_en)) == len_q) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (words_left_q == LEN_W'(1))) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed self-checking bench for the FIFO drain controller.
// A queue models the FIFO read port with one-cycle read latency.
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] xfer_len = '0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [3:0] words_left;

  logic [7:0] fq [$];
  logic       hold_empty = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q [$];
  logic       last_q [$];
  int rd_cnt, rd_stall, rd_empty, done_cnt, hold_viol;

  fifo_drain_ctrl #(
    .DATA_W     (8),
    .LEN_W      (4),
    .SKID_DEPTH (2)
  ) dut (
    .read_clk   (clk),
    .reset      (reset),
    .start      (start),
    .xfer_len   (xfer_len),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .words_left (words_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() != 0) fifo_data <= fq.pop_front();
    end
    #2;
    fifo_empty = hold_empty || (fq.size() == 0);
  end

  task automatic start_xfer(input logic [3:0] len);
    @(posedge clk); #1;
    start = 1'b1;
    xfer_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    xfer_len = '0;
  endtask

  task automatic run_capture(input int ready_from, input int elo,
                             input int ehi, input int max_cyc);
    bit pstall;
    logic [7:0] pdata;
    got_q.delete();
    last_q.delete();
    rd_cnt = 0; rd_stall = 0; rd_empty = 0;
    done_cnt = 0; hold_viol = 0;
    pstall = 0; pdata = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      out_ready = (i >= ready_from);
      hold_empty = (i >= elo) && (i <= ehi);
      @(negedge clk);
      if (fifo_rd_en) begin
        rd_cnt++;
        if (!out_ready) rd_stall++;
        if (fifo_empty) rd_empty++;
      end
      if (out_valid && !out_ready) begin
        if (pstall && out_data !== pdata) hold_viol++;
        pstall = 1;
        pdata = out_data;
      end else begin
        pstall = 0;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (done) begin
        done_cnt++;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    hold_empty = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({fifo_rd_en, out_valid, out_last, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {fifo_rd_en, out_valid, out_last, busy, done});
    end
    checks++;
    if (words_left !== 4'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got wl=%0d d=%0h exp 0 0",
               words_left, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b rd=%b exp 0 0",
               busy, fifo_rd_en);
    end
  endtask

  task automatic test_basic;
    logic [0:6] e_rd = 7'b1110000;
    logic [0:6] e_vl = 7'b0011100;
    logic [0:6] e_ls = 7'b0000100;
    logic [0:6] e_dn = 7'b0000010;
    logic [0:6] e_bz = 7'b1111110;
    logic [3:0] e_wl [7] = '{3, 3, 3, 2, 1, 0, 0};
    logic [7:0] e_d  [7] = '{0, 0, 8'hA1, 8'hB2, 8'hC3, 0, 0};
    fq = {8'hA1, 8'hB2, 8'hC3};
    out_ready = 1'b1;
    start_xfer(4'd3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if ({fifo_rd_en, out_valid, out_last, done, busy} !==
          {e_rd[i], e_vl[i], e_ls[i], e_dn[i], e_bz[i]}) begin
        errors++;
        $display("FAIL basic_flags T%0d got %b exp %b", i + 1,
                 {fifo_rd_en, out_valid, out_last, done, busy},
                 {e_rd[i], e_vl[i], e_ls[i], e_dn[i], e_bz[i]});
      end
      checks++;
      if (words_left !== e_wl[i]) begin
        errors++;
        $display("FAIL basic_wl T%0d got %0d exp %0d", i + 1,
                 words_left, e_wl[i]);
      end
      if (e_vl[i]) begin
        checks++;
        if (out_data !== e_d[i]) begin
          errors++;
          $display("FAIL basic_data T%0d got %0h exp %0h", i + 1,
                   out_data, e_d[i]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    fq = {8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    start_xfer(4'd4);
    run_capture(6, 99, 0, 40);
    checks++;
    if (rd_stall !== 2) begin
      errors++;
      $display("FAIL bp_stall_reads got %0d exp 2", rd_stall);
    end
    checks++;
    if (hold_viol !== 0) begin
      errors++;
      $display("FAIL bp_hold got %0d changes exp 0", hold_viol);
    end
    checks++;
    if (got_q.size() !== 4 || done_cnt !== 1) begin
      errors++;
      $display("FAIL bp_count got n=%0d done=%0d exp 4 1",
               got_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp_d[i] || last_q[i] !== (i == 3)) begin
          errors++;
          $display("FAIL bp_word%0d got %0h/%b exp %0h/%b", i,
                   got_q[i], last_q[i], exp_d[i], i == 3);
        end
      end
    end
  endtask

  task automatic test_empty_stall;
    fq = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    start_xfer(4'd5);
    run_capture(1, 2, 6, 40);
    checks++;
    if (rd_empty !== 0 || rd_cnt !== 5) begin
      errors++;
      $display("FAIL empty_reads got empty=%0d n=%0d exp 0 5",
               rd_empty, rd_cnt);
    end
    checks++;
    if (got_q.size() !== 5 || done_cnt !== 1) begin
      errors++;
      $display("FAIL empty_count got n=%0d done=%0d exp 5 1",
               got_q.size(), done_cnt);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== 8'(i + 1)) begin
          errors++;
          $display("FAIL empty_word%0d got %0h exp %0h", i,
                   got_q[i], i + 1);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (words_left !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_end got wl=%0d busy=%b exp 0 0",
               words_left, busy);
    end
  endtask

  task automatic test_zero_len;
    fq.delete();
    start_xfer(4'd0);
    @(negedge clk);
    checks++;
    if ({busy, done, fifo_rd_en, out_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL zero_t1 got %b exp 1100",
               {busy, done, fifo_rd_en, out_valid});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({busy, done, fifo_rd_en, out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_t2 got %b exp 0000",
               {busy, done, fifo_rd_en, out_valid});
    end
  endtask

  task automatic test_reset_mid;
    fq = {8'hE1, 8'hE2, 8'hE3, 8'hE4};
    out_ready = 1'b0;
    start_xfer(4'd4);
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hE1) begin
      errors++;
      $display("FAIL mid_pre got v=%b d=%0h exp 1 e1",
               out_valid, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({fifo_rd_en, out_valid, out_last, busy, done} !== 5'b0 ||
        words_left !== 4'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset got %b wl=%0d d=%0h exp 00000 0 0",
               {fifo_rd_en, out_valid, out_last, busy, done},
               words_left, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    fq = {8'h5A};
    start_xfer(4'd1);
    run_capture(1, 99, 0, 20);
    checks++;
    if (got_q.size() !== 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL fresh_count got n=%0d done=%0d exp 1 1",
               got_q.size(), done_cnt);
    end else begin
      checks++;
      if (got_q[0] !== 8'h5A || last_q[0] !== 1'b1) begin
        errors++;
        $display("FAIL fresh_word got %0h/%b exp 5a/1",
                 got_q[0], last_q[0]);
      end
    end
  endtask

  task automatic test_restart_ignored;
    fq = {8'h31, 8'h32, 8'h33};
    out_ready = 1'b0;
    start_xfer(4'd3);
    @(posedge clk); #1;
    start = 1'b1;
    xfer_len = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    xfer_len = '0;
    @(negedge clk);
    checks++;
    if (words_left !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_wl got wl=%0d busy=%b exp 3 1",
               words_left, busy);
    end
    @(posedge clk); #1;
    run_capture(1, 99, 0, 20);
    checks++;
    if (rd_cnt !== 1 || got_q.size() !== 3 || done_cnt !== 1) begin
      errors++;
      $display("FAIL restart_xfer got rd=%0d n=%0d done=%0d exp 1 3 1",
               rd_cnt, got_q.size(), done_cnt);
    end else begin
      checks++;
      if (got_q[2] !== 8'h33 || last_q[2] !== 1'b1) begin
        errors++;
        $display("FAIL restart_last got %0h/%b exp 33/1",
                 got_q[2], last_q[2]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_idle got busy=%b exp 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_zero_len();
    test_reset_mid();
    test_restart_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
